// File: rtl/morse_rx.sv
// morse_rx: samples a keyed pin, measures mark/space runs in Morse units,
// decodes letters. Optional MORSE_RX_GLITCH_FILTER_EN debounces the input.
module morse_rx #(
  parameter int UNIT_CYCLES = 2097152,
  parameter int MAX_ELEMS   = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PIN_IN,
  output logic                 SYM_VALID,
  output logic [MAX_ELEMS-1:0] SYM_BITS,
  output logic [2:0]           SYM_LEN,
  output logic                 WORD_VALID,
  output logic                 ERR
);

  localparam int CW = $clog2(5*UNIT_CYCLES+1);
  localparam logic [CW-1:0] T5   = CW'(5*UNIT_CYCLES);
  localparam logic [CW-1:0] T2M1 = CW'(2*UNIT_CYCLES-1);
  localparam logic [CW-1:0] T5M1 = CW'(5*UNIT_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE, MARK, LONG, SPACE, GAP
  } state_t;

  logic sync1_q, sync2_q;
  logic lvl_q, lvl_d;
  logic edge_det, rise, fall;

  // Level regs reset high so a mark held across reset never looks like a rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
    end else begin
      sync1_q <= PIN_IN;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
    end
  end

`ifdef MORSE_RX_GLITCH_FILTER_EN
  localparam int FLT = (UNIT_CYCLES/8 < 1) ? 1 : UNIT_CYCLES/8;
  localparam int FW  = $clog2(FLT+1);

  logic [FW-1:0] flt_q, flt_d;

  always_comb begin
    flt_d    = '0;
    lvl_d    = lvl_q;
    edge_det = 1'b0;
    if (sync2_q != lvl_q) begin
      if (flt_q == FW'(FLT)) begin
        edge_det = 1'b1;
        lvl_d    = sync2_q;
      end else begin
        flt_d = flt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) flt_q <= '0;
    else     flt_q <= flt_d;
  end
`else
  always_comb begin
    lvl_d    = sync2_q;
    edge_det = sync2_q ^ lvl_q;
  end
`endif

  assign rise = edge_det & lvl_d;
  assign fall = edge_det & ~lvl_d;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [MAX_ELEMS-1:0] bits_q, bits_d;
  logic [2:0]           len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic                 sym_valid_q, sym_valid_d;
  logic [MAX_ELEMS-1:0] sym_bits_q, sym_bits_d;
  logic [2:0]           sym_len_q, sym_len_d;
  logic                 word_valid_q, word_valid_d;
  logic                 err_q, err_d;
  logic                 at2, at5, is_dash;

  always_comb begin
    if (edge_det)          count_d = '0;
    else if (count_q == T5) count_d = count_q;
    else                   count_d = count_q + CW'(1);

    state_d      = state_q;
    bits_d       = bits_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    sym_valid_d  = 1'b0;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;
    at2          = (count_q == T2M1);
    at5          = (count_q == T5M1);
    is_dash      = (count_q >= T2M1);

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = MARK;
      end
      MARK: begin
        if (at5) begin
          err_d   = 1'b1;
          bits_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = fall ? IDLE : LONG;
        end else if (fall) begin
          if (len_q == 3'(MAX_ELEMS)) begin
            ovf_d = 1'b1;
          end else begin
            for (int i = 0; i < MAX_ELEMS; i++)
              if (len_q == 3'(i)) bits_d[i] = is_dash;
            len_d = len_q + 3'd1;
          end
          state_d = SPACE;
        end
      end
      LONG: begin
        if (fall) state_d = IDLE;
      end
      SPACE: begin
        // Letter end wins over a rise landing on the same cycle.
        if (at2) begin
          if (ovf_q) begin
            err_d = 1'b1;
          end else begin
            sym_valid_d = 1'b1;
            sym_bits_d  = bits_q;
            sym_len_d   = len_q;
          end
          bits_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = rise ? MARK : GAP;
        end else if (rise) begin
          state_d = MARK;
        end
      end
      GAP: begin
        if (at5) word_valid_d = 1'b1;
        if (rise)     state_d = MARK;
        else if (at5) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      count_q      <= '0;
      bits_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_bits_q   <= '0;
      sym_len_q    <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bits_q       <= bits_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      sym_valid_q  <= sym_valid_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  assign SYM_VALID  = sym_valid_q;
  assign SYM_BITS   = sym_bits_q;
  assign SYM_LEN    = sym_len_q;
  assign WORD_VALID = word_valid_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx: drives keyed waveforms into morse_rx and compares strobes
// against a run-length reference model.
module tb_morse_rx;

  localparam int U  = 16;
  localparam int T2 = 2*U;
  localparam int T5 = 5*U;
  localparam int ME = 6;
`ifdef MORSE_RX_GLITCH_FILTER_EN
  localparam int FLT  = U/8;
  localparam bit FILT = 1'b1;
`else
  localparam int FLT  = 0;
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT = 2 + FLT;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PIN_IN = 1'b0;
  logic          SYM_VALID;
  logic [ME-1:0] SYM_BITS;
  logic [2:0]    SYM_LEN;
  logic          WORD_VALID;
  logic          ERR;

  morse_rx #(.UNIT_CYCLES(U), .MAX_ELEMS(ME)) dut (
    .CLK(CLK), .RST(RST), .PIN_IN(PIN_IN),
    .SYM_VALID(SYM_VALID), .SYM_BITS(SYM_BITS), .SYM_LEN(SYM_LEN),
    .WORD_VALID(WORD_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // event = {kind, cycle, bits, len}; kind 0 sym, 1 word, 2 err
  typedef logic [44:0] ev_t;
  typedef struct { bit lvl; int len; } seg_t;

  ev_t  act_q[$];
  ev_t  exp_q[$];
  seg_t segs[$];
  int   base;
  int   overlap = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (SYM_VALID)  act_q.push_back({4'd0, 32'(cyc), SYM_BITS, SYM_LEN});
      if (WORD_VALID) act_q.push_back({4'd1, 32'(cyc), 9'd0});
      if (ERR)        act_q.push_back({4'd2, 32'(cyc), 9'd0});
      if (SYM_VALID && ERR) overlap++;
    end
  end

  function automatic void add(input bit l, input int n);
    seg_t s;
    s.lvl = l;
    s.len = n;
    segs.push_back(s);
  endfunction

  // Reference: merge filtered runs, then apply the mark/space length rules.
  function automatic void model();
    seg_t runs[$];
    seg_t r;
    int t, n, L;
    bit l, ab;
    logic [ME-1:0] b;
    r.lvl = 1'b0;
    r.len = 0;
    runs.push_back(r);
    foreach (segs[i]) begin
      l = segs[i].lvl;
      if (FILT && segs[i].len <= FLT) l = runs[runs.size()-1].lvl;
      if (runs[runs.size()-1].lvl == l) begin
        runs[runs.size()-1].len += segs[i].len;
      end else begin
        r.lvl = l;
        r.len = segs[i].len;
        runs.push_back(r);
      end
    end
    t = base; n = 0; b = '0; ab = 1'b0;
    foreach (runs[i]) begin
      L = runs[i].len;
      if (runs[i].lvl) begin
        if (L >= T5) begin
          exp_q.push_back({4'd2, 32'(t+LAT+T5), 9'd0});
          n = 0; b = '0; ab = 1'b1;
        end else begin
          ab = 1'b0;
          if (n < ME) b[n] = (L >= T2);
          n++;
        end
      end else if (!ab && n > 0 && L >= T2) begin
        if (n > ME) exp_q.push_back({4'd2, 32'(t+LAT+T2), 9'd0});
        else        exp_q.push_back({4'd0, 32'(t+LAT+T2), b, 3'(n)});
        n = 0; b = '0;
        if (L >= T5) exp_q.push_back({4'd1, 32'(t+LAT+T5), 9'd0});
      end
      t += L;
    end
  endfunction

  task automatic drive(input bit l, input int n);
    for (int i = 0; i < n; i++) begin
      PIN_IN = l;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic run_segs();
    act_q.delete();
    exp_q.delete();
    base = cyc + 1;
    foreach (segs[i]) drive(segs[i].lvl, segs[i].len);
    drive(1'b0, 10);
    model();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    PIN_IN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_chk++; if (SYM_VALID !== 1'b0) $display("FAIL rst_sym_valid: got %b need 0", SYM_VALID); else n_pass++;
    n_chk++; if (WORD_VALID !== 1'b0) $display("FAIL rst_word_valid: got %b need 0", WORD_VALID); else n_pass++;
    n_chk++; if (ERR !== 1'b0) $display("FAIL rst_err: got %b need 0", ERR); else n_pass++;
    n_chk++; if (SYM_BITS !== '0) $display("FAIL rst_sym_bits: got %b need 0", SYM_BITS); else n_pass++;
    n_chk++; if (SYM_LEN !== 3'd0) $display("FAIL rst_sym_len: got %0d need 0", SYM_LEN); else n_pass++;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(1'b0, 100);
  endtask

  task automatic test_sos();
    logic [26:0] p;
    p = 27'b101010001110111011100010101;
    segs.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 27; i++) add(p[i], 16);
      add(1'b0, 80);
    end
    add(1'b0, 100);
    run_segs();
    n_chk++;
    if (exp_q.size() != 8 || act_q.size() !== exp_q.size())
      $display("FAIL sos_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL sos_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_boundaries();
    segs.delete();
    add(1'b1, T2-1); add(1'b0, 100);
    add(1'b1, T2);   add(1'b0, 100);
    add(1'b1, 16); add(1'b0, T2-1); add(1'b1, 16); add(1'b0, 100);
    add(1'b1, 16); add(1'b0, T2);   add(1'b1, 40); add(1'b0, T5-1);
    add(1'b1, 16); add(1'b0, 100);
    run_segs();
    n_chk++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL bnd_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL bnd_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_long_mark();
    segs.delete();
    add(1'b1, T5);  add(1'b0, 100);
    add(1'b1, 120); add(1'b0, 50);
    add(1'b1, 16);  add(1'b0, 100);
    run_segs();
    n_chk++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL long_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL long_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    segs.delete();
    for (int i = 0; i < 7; i++) begin
      add(1'b1, 16);
      add(1'b0, (i == 6) ? 100 : 16);
    end
    for (int i = 0; i < 6; i++) begin
      add(1'b1, (i == 2) ? 40 : 16);
      add(1'b0, (i == 5) ? 100 : 16);
    end
    run_segs();
    n_chk++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL ovf_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL ovf_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    act_q.delete();
    drive(1'b1, 48);
    drive(1'b0, 16);
    drive(1'b1, 20);
    RST = 1'b1;
    drive(1'b1, 2);
    RST = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({SYM_VALID, WORD_VALID, ERR, SYM_BITS, SYM_LEN} !== '0)
      $display("FAIL rmid_outs: got %b need 0", {SYM_VALID, WORD_VALID, ERR, SYM_BITS, SYM_LEN});
    else n_pass++;
    @(posedge CLK);
    #1;
    drive(1'b1, 28);
    drive(1'b0, 100);
    n_chk++;
    if (act_q.size() !== 0) $display("FAIL rmid_quiet: got %0d events need 0", act_q.size());
    else n_pass++;
    segs.delete();
    for (int i = 0; i < 3; i++) begin
      add(1'b1, 16);
      add(1'b0, (i == 2) ? 100 : 16);
    end
    run_segs();
    n_chk++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL rmid_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL rmid_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    segs.delete();
    add(1'b1, 16);
    for (int i = 0; i < 6; i++) begin
      add(1'b0, 9);
      add(1'b1, 1);
    end
    add(1'b0, 4);
    add(1'b1, 40);
    add(1'b0, 100);
    run_segs();
    n_chk++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL glitch_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL glitch_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int ne;
    ev_t last;
    segs.delete();
    for (int k = 0; k < 10; k++) begin
      ne = $urandom_range(1, 7);
      for (int e = 0; e < ne; e++) begin
        if ($urandom_range(0, 1) == 1) add(1'b1, $urandom_range(T2, T5-1));
        else                           add(1'b1, $urandom_range(6, T2-1));
        if (e != ne-1) add(1'b0, $urandom_range(6, T2-1));
      end
      add(1'b0, $urandom_range(T2, T5+10));
    end
    add(1'b0, 100);
    run_segs();
    n_chk++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL rand_count: got %0d need %0d", act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i])
        $display("FAIL rand_ev%0d: got %h need %h", i, (i < act_q.size()) ? act_q[i] : '1, exp_q[i]);
      else n_pass++;
    end
    last = '0;
    foreach (exp_q[i]) if (exp_q[i][44:41] == 4'd0) last = exp_q[i];
    @(negedge CLK);
    n_chk++;
    if ({SYM_BITS, SYM_LEN} !== last[8:0])
      $display("FAIL rand_hold: got %b need %b", {SYM_BITS, SYM_LEN}, last[8:0]);
    else n_pass++;
    n_chk++;
    if (overlap !== 0) $display("FAIL sym_err_overlap: got %0d need 0", overlap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sos();
    test_boundaries();
    test_long_mark();
    test_overflow();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
